// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - captures a multiplexed active-low 7-seg bus back into 4-bit codes
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        err
);

  localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [15:0] AGE_LIMIT  = 16'(TIMEOUT_CYCLES);

  logic [3:0]  an_m, an_s;
  logic [6:0]  seg_m, seg_s;
  logic [7:0]  cnt;
  logic [15:0] age [4];

  logic        changed, capture, one_hot, blank;
  logic [1:0]  idx;
  logic [4:0]  dec;

  // Returns {legal, code}; legal = 0 for any pattern outside the 16-entry table.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = {1'b1, 4'h0};
      7'b1001111: decode = {1'b1, 4'h1};
      7'b0010010: decode = {1'b1, 4'h2};
      7'b0000110: decode = {1'b1, 4'h3};
      7'b1001100: decode = {1'b1, 4'h4};
      7'b0100100: decode = {1'b1, 4'h5};
      7'b0100000: decode = {1'b1, 4'h6};
      7'b0001111: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0000100: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b1100000: decode = {1'b1, 4'hB};
      7'b0110001: decode = {1'b1, 4'hC};
      7'b1000010: decode = {1'b1, 4'hD};
      7'b1111111: decode = {1'b1, 4'hE};
      7'b0011000: decode = {1'b1, 4'hF};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    changed = {an_m, seg_m} != {an_s, seg_s};
    // cnt only passes through STABLE_MAX-1 once per episode, so this fires once.
    capture = !changed && (cnt == STABLE_MAX - 8'd1);
    blank   = (an_s == 4'b1111);
    dec     = decode(seg_s);
    one_hot = 1'b1;
    idx     = 2'd0;
    case (an_s)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_m    <= 4'b1111;
      an_s    <= 4'b1111;
      seg_m   <= 7'b1111111;
      seg_s   <= 7'b1111111;
      cnt     <= 8'd0;
      digits  <= 16'hEEEE;
      valid   <= 4'b0000;
      upd     <= 1'b0;
      err     <= 1'b0;
      upd_idx <= 2'd0;
      for (int i = 0; i < 4; i++) age[i] <= 16'd0;
    end else begin
      an_m  <= an;
      an_s  <= an_m;
      seg_m <= seg;
      seg_s <= seg_m;

      if (changed)                cnt <= 8'd0;
      else if (cnt != STABLE_MAX) cnt <= cnt + 8'd1;

      upd <= 1'b0;
      err <= 1'b0;

      for (int i = 0; i < 4; i++) begin
        if (capture && one_hot && idx == 2'(i)) begin
          age[i] <= 16'd0;
        end else begin
          if (age[i] != 16'hFFFF) age[i] <= age[i] + 16'd1;
          if (age[i] == AGE_LIMIT - 16'd1) begin
            valid[i]         <= 1'b0;
            digits[4*i +: 4] <= 4'hE;
          end
        end
      end

      // Placed after the timeout loop so a same-edge capture overrides the blanking.
      if (capture) begin
        if (one_hot) begin
          upd_idx <= idx;
          if (dec[4]) begin
            digits[4*idx +: 4] <= dec[3:0];
            valid[idx]         <= 1'b1;
            upd                <= 1'b1;
          end else begin
            valid[idx] <= 1'b0;
            err        <= 1'b1;
          end
        end else if (!blank) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed and random checks of seg_scan_decoder against a timestamp model
module tb_seg_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 100;
  localparam logic [6:0] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b1111111, 7'b0011000};
  localparam logic [3:0] BLANK_AN  = 4'b1111;
  localparam logic [6:0] BLANK_SEG = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg = 7'b1111111;
  logic [3:0]  an  = 4'b1111;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        err;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .digits(digits), .valid(valid), .upd(upd), .upd_idx(upd_idx), .err(err));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: edge counter plus timestamps of the last sampled-pair change and last capture per digit.
  int          n = 0;
  logic [10:0] in_prev, s_pair;
  int          last_change;
  int          last_cap [4];
  int          cap_edge;
  logic [15:0] e_digits;
  logic [3:0]  e_valid;
  logic        e_upd, e_err;
  logic [1:0]  e_idx;
  int          upd_cnt, err_cnt, upd_at;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_prev     = {BLANK_AN, BLANK_SEG};
    s_pair      = {BLANK_AN, BLANK_SEG};
    last_change = n;
    for (int i = 0; i < 4; i++) last_cap[i] = n;
    e_digits = 16'hEEEE; e_valid = 4'b0; e_upd = 1'b0; e_err = 1'b0; e_idx = 2'd0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
    logic [10:0] arriving;
    int          lows, cap_i, code;
    arriving = in_prev;
    in_prev  = {a, s};
    if (arriving != s_pair) begin
      s_pair      = arriving;
      last_change = n;
    end
    e_upd = 1'b0; e_err = 1'b0; cap_i = -1;
    if (n - last_change == STABLE) begin
      lows = 0;
      for (int i = 0; i < 4; i++) if (!s_pair[7+i]) begin lows++; cap_i = i; end
      if (lows == 1) begin
        e_idx          = 2'(cap_i);
        last_cap[cap_i] = n;
        code = -1;
        for (int c = 0; c < 16; c++) if (PAT[c] == s_pair[6:0]) code = c;
        if (code >= 0) begin
          e_digits[4*cap_i +: 4] = 4'(code);
          e_valid[cap_i] = 1'b1;
          e_upd = 1'b1;
          cap_edge = n;
        end else begin
          e_valid[cap_i] = 1'b0;
          e_err = 1'b1;
        end
      end else begin
        cap_i = -1;
        if (lows > 1) e_err = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++)
      if (i != cap_i && n - last_cap[i] == TIMEOUT) begin
        e_valid[i] = 1'b0;
        e_digits[4*i +: 4] = 4'hE;
      end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s);
    an = a; seg = s;
    @(posedge clk);
    n++;
    model_edge(a, s);
    #1;
    chk("digits",  digits,  e_digits);
    chk("valid",   16'(valid),   16'(e_valid));
    chk("upd",     16'(upd),     16'(e_upd));
    chk("err",     16'(err),     16'(e_err));
    chk("upd_idx", 16'(upd_idx), 16'(e_idx));
    chk("upd_err_excl", 16'(upd & err), 16'd0);
    if (upd) upd_cnt++;
    if (err) err_cnt++;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    an = BLANK_AN; seg = BLANK_SEG;
    #1;
    chk("rst_digits", digits, 16'hEEEE);
    chk("rst_valid",  16'(valid), 16'd0);
    chk("rst_upd",    16'(upd), 16'd0);
    chk("rst_err",    16'(err), 16'd0);
    chk("rst_idx",    16'(upd_idx), 16'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int cycles);
    for (int k = 0; k < cycles; k++) step(a, s);
  endtask

  initial begin
    logic [3:0] ra;
    logic [6:0] rs;
    int         len;

    #1;
    do_reset();

    // Reset landing in the middle of a settling episode.
    hold(4'b0111, 7'b0000000, 3);
    do_reset();

    // Single capture: upd on the sixth edge after the inputs change.
    an = 4'b1110; seg = 7'b0010010;
    upd_at = -1;
    for (int k = 0; k < 8; k++) begin
      step(4'b1110, 7'b0010010);
      if (upd && upd_at < 0) upd_at = k;
    end
    chk("single_upd_edge", 16'(upd_at), 16'd5);
    chk("single_digit",    16'(digits[3:0]), 16'h2);
    chk("single_valid",    16'(valid), 16'b0001);
    chk("single_idx",      16'(upd_idx), 16'd0);

    // Scan 1, F, E, 0 across digits 0..3.
    upd_cnt = 0; err_cnt = 0;
    hold(4'b1110, PAT[1],  10); hold(BLANK_AN, BLANK_SEG, 3);
    hold(4'b1101, PAT[15], 10); hold(BLANK_AN, BLANK_SEG, 3);
    hold(4'b1011, PAT[14], 10); hold(BLANK_AN, BLANK_SEG, 3);
    hold(4'b0111, PAT[0],  10); hold(BLANK_AN, BLANK_SEG, 3);
    chk("scan_digits", digits, 16'h0EF1);
    chk("scan_valid",  16'(valid), 16'hF);
    chk("scan_upds",   16'(upd_cnt), 16'd4);
    chk("scan_errs",   16'(err_cnt), 16'd0);

    // Glitch on digit 1 shorter than the settle window.
    err_cnt = 0;
    hold(4'b1101, 7'b1001111, 10);
    hold(4'b1101, 7'b0000000, 2);
    hold(4'b1101, 7'b1001111, 10);
    chk("glitch_errs",  16'(err_cnt), 16'd0);
    chk("glitch_digit", 16'(digits[7:4]), 16'h1);

    // Illegal segment pattern, then two strobes low.
    err_cnt = 0;
    hold(4'b1101, 7'b1110000, 8);
    chk("illseg_err",   16'(err_cnt), 16'd1);
    chk("illseg_valid", 16'(valid[1]), 16'd0);
    chk("illseg_digit", 16'(digits[7:4]), 16'h1);
    err_cnt = 0;
    hold(4'b1100, 7'b0000000, 8);
    chk("multi_err",   16'(err_cnt), 16'd1);
    chk("multi_valid", 16'(valid), 16'b1101);

    // Timeout of digit 2 after blanking only.
    cap_edge = -1;
    hold(4'b1011, PAT[9], 6);
    while (n < cap_edge + TIMEOUT) step(BLANK_AN, BLANK_SEG);
    chk("tmo_valid", 16'(valid[2]), 16'd0);
    chk("tmo_digit", 16'(digits[11:8]), 16'hE);

    // Re-capture landing exactly on the timeout edge.
    hold(4'b1011, PAT[9], 6);
    len = cap_edge;
    while (n + 1 < len + TIMEOUT - 5) step(BLANK_AN, BLANK_SEG);
    while (n < len + TIMEOUT) step(4'b1011, PAT[9]);
    chk("race_valid", 16'(valid[2]), 16'd1);
    chk("race_digit", 16'(digits[11:8]), 16'h9);

    // Randomized traffic, including short holds and illegal strobes/patterns.
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 6))
        0: ra = 4'b1110;
        1: ra = 4'b1101;
        2: ra = 4'b1011;
        3: ra = 4'b0111;
        4, 5: ra = BLANK_AN;
        default: ra = 4'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) rs = 7'($urandom);
      else rs = PAT[$urandom_range(0, 15)];
      len = $urandom_range(1, 9);
      hold(ra, rs, len);
      if (it == 120) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
